// File: rtl/jk_counter_param.sv
// Parameterised counter: up, down, bounce (ping-pong) or Gray-up sequencing over 0..MAX,
// with synchronous saturating load, count enable and a registered terminal-count pulse.
module jk_counter_param #(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             dir
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
    localparam logic [1:0] M_UP     = 2'b00;
    localparam logic [1:0] M_DOWN   = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;
    localparam logic [1:0] M_GRAY   = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] q_inc, q_dec, load_sat;

    assign q_inc    = q_q + ONE_V;
    assign q_dec    = q_q - ONE_V;
    assign load_sat = (load_val > MAX_V) ? MAX_V : load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            dir_q <= 1'b1;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    always_comb begin
        q_d   = q_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (load) begin
            q_d = load_sat;
            if (load_sat == MAX_V)   dir_d = 1'b0;
            else if (load_sat == '0) dir_d = 1'b1;
        end else if (en) begin
            case (mode)
                M_UP, M_GRAY: begin
                    if (q_q == MAX_V) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_inc;
                    end
                end
                M_DOWN: begin
                    if (q_q == '0) begin
                        q_d  = MAX_V;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_dec;
                    end
                end
                M_BOUNCE: begin
                    // the end-stop cases cover a mode switch that left q at a bound facing outward
                    if (dir_q && q_q != MAX_V) begin
                        q_d = q_inc;
                        if (q_inc == MAX_V) dir_d = 1'b0;
                    end else if (dir_q) begin
                        q_d   = q_dec;
                        dir_d = 1'b0;
                    end else if (q_q != '0) begin
                        q_d = q_dec;
                        if (q_dec == '0) dir_d = 1'b1;
                    end else begin
                        q_d   = q_inc;
                        dir_d = 1'b1;
                    end
                    tc_d = (q_d == MAX_V) || (q_d == '0);
                end
                default: ;
            endcase
        end
    end

    assign count = (mode == M_GRAY) ? (q_q ^ (q_q >> 1)) : q_q;
    assign tc    = tc_q;
    assign dir   = dir_q;

endmodule

// File: tb/tb_jk_counter_param.sv
// Directed bench for jk_counter_param: three instances cover up/Gray (4b,15), down (4b,9)
// and bounce (3b,5); expected sequences are hand-written tables.
module tb_jk_counter_param;

    logic clk, reset;
    logic       en_a, load_a, tc_a, dir_a;
    logic [3:0] lv_a, cnt_a;
    logic [1:0] mode_a;
    logic       en_b, load_b, tc_b, dir_b;
    logic [3:0] lv_b, cnt_b;
    logic [1:0] mode_b;
    logic       en_c, load_c, tc_c, dir_c;
    logic [2:0] lv_c, cnt_c;
    logic [1:0] mode_c;

    int n_chk  = 0;
    int n_pass = 0;

    jk_counter_param #(.WIDTH(4), .MAX(15)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .load(load_a), .load_val(lv_a),
        .mode(mode_a), .count(cnt_a), .tc(tc_a), .dir(dir_a));
    jk_counter_param #(.WIDTH(4), .MAX(9)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .load(load_b), .load_val(lv_b),
        .mode(mode_b), .count(cnt_b), .tc(tc_b), .dir(dir_b));
    jk_counter_param #(.WIDTH(3), .MAX(5)) u_c (
        .clk(clk), .reset(reset), .en(en_c), .load(load_c), .load_val(lv_c),
        .mode(mode_c), .count(cnt_c), .tc(tc_c), .dir(dir_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int unsigned bnc_cnt [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    int unsigned bnc_dir [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    int unsigned gray_tbl[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        logic [3:0] prev;
        int e;
        reset = 1'b0;
        {en_a, load_a, lv_a, mode_a} = '0;
        {en_b, load_b, lv_b, mode_b} = '0;
        {en_c, load_c, lv_c, mode_c} = '0;
        step();
        chk("rst_cnt", cnt_a, 0);
        chk("rst_tc",  tc_a, 0);
        chk("rst_dir", dir_a, 1);

        // up, full range
        reset = 1'b1;
        en_a  = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("up_cnt", cnt_a, i % 16);
            chk("up_tc",  tc_a, (i == 16));
        end
        en_a = 1'b0;

        // down, MAX=9
        mode_b = 2'b01;
        en_b   = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            e = (i % 10 == 0) ? 0 : 10 - (i % 10);
            chk("dn_cnt", cnt_b, e);
            chk("dn_tc",  tc_b, (e == 9));
        end
        load_b = 1'b1;
        lv_b   = 4'd12;
        step();
        chk("ld_sat_cnt", cnt_b, 9);
        chk("ld_sat_tc",  tc_b, 0);
        chk("ld_sat_dir", dir_b, 0);
        {load_b, en_b} = '0;

        // bounce, WIDTH=3 MAX=5
        mode_c = 2'b10;
        en_c   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("bnc_cnt", cnt_c, bnc_cnt[i]);
            chk("bnc_dir", dir_c, bnc_dir[i]);
            chk("bnc_tc",  tc_c, (bnc_cnt[i] == 5 || bnc_cnt[i] == 0));
        end
        en_c = 1'b0;

        // Gray, from a loaded 0
        load_a = 1'b1;
        lv_a   = 4'd0;
        step();
        chk("ld0_cnt", cnt_a, 0);
        load_a = 1'b0;
        mode_a = 2'b11;
        en_a   = 1'b1;
        prev   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("gray_cnt", cnt_a, gray_tbl[i]);
            chk("gray_1bit", $countones(prev ^ cnt_a), 1);
            chk("gray_tc", tc_a, (i == 15));
            prev = cnt_a;
        end

        // async reset mid-count at q=7
        en_a   = 1'b0;
        mode_a = 2'b00;
        load_a = 1'b1;
        lv_a   = 4'd7;
        step();
        chk("ld7_cnt", cnt_a, 7);
        load_a = 1'b0;
        en_a   = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("arst_cnt", cnt_a, 0);
        chk("arst_tc",  tc_a, 0);
        chk("arst_dir", dir_a, 1);
        chk("arst_b_cnt", cnt_b, 0);
        chk("arst_b_dir", dir_b, 1);
        #1 reset = 1'b1;
        step();
        chk("rel_cnt", cnt_a, 1);

        // load beats enable, then hold
        load_a = 1'b1;
        lv_a   = 4'd3;
        step();
        chk("ld_en_cnt", cnt_a, 3);
        chk("ld_en_tc",  tc_a, 0);
        load_a = 1'b0;
        en_a   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_cnt", cnt_a, 3);
            chk("hold_tc",  tc_a, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
